uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with optional parity and runtime baud divisor
module uart_tx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 txd,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           data_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 txd_q;

    // Gated by resetn so the upstream FIFO never pops while we are held in reset.
    assign in_ready = (state_q == IDLE) && resetn;
    assign busy     = (state_q != IDLE);
    assign txd      = txd_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (in_valid) begin
                        data_q    <= in_data;
                        div_q     <= divisor;
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_odd;
                        cnt_q     <= divisor;
                        txd_q     <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        cnt_q     <= div_q;
                        bit_idx_q <= 3'd0;
                        txd_q     <= data_q[0];
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= div_q;
                        if (bit_idx_q == 3'd7) begin
                            if (par_en_q) begin
                                txd_q   <= (^data_q) ^ par_odd_q;
                                state_q <= PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= data_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= div_q;
                        txd_q   <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    txd_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] divisor;
    logic        parity_en;
    logic        parity_odd;
    logic        txd;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int h0;
    int bad;

    always #5 clk = ~clk;

    uart_tx #(.DIV_WIDTH(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .divisor   (divisor),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .txd       (txd),
        .busy      (busy)
    );

    // Bytes consumed from the FIFO: every edge where both sides agree.
    always @(posedge clk) begin
        if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle and the byte already presented.
    task automatic frame(input string tag, input logic [7:0] b, input int d,
                         input logic pe, input logic po,
                         input logic [7:0] nxt_data, input logic nxt_valid,
                         input int chg_k, input logic [15:0] chg_div);
        logic [10:0] bits;
        int nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        if (pe) bits[9] = (^b) ^ po;
        nb = pe ? 11 : 10;
        chk($sformatf("%s.rdy", tag), {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < nb * (d + 1); k++) begin
            @(negedge clk);
            chk($sformatf("%s.txd%0d", tag, k), {31'd0, txd}, {31'd0, bits[k / (d + 1)]});
            chk($sformatf("%s.busy%0d", tag, k), {31'd0, busy}, 32'd1);
            if (k == 0) begin
                chk($sformatf("%s.rdy_lo", tag), {31'd0, in_ready}, 32'd0);
                in_data  = nxt_data;
                in_valid = nxt_valid;
            end
            if (k == chg_k) divisor = chg_div;
        end
        @(negedge clk);
        chk($sformatf("%s.idle_txd", tag), {31'd0, txd}, 32'd1);
        chk($sformatf("%s.idle_busy", tag), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        divisor    = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        @(negedge clk);
        chk("rst.rdy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst.txd", {31'd0, txd}, 32'd1);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.rdy2", {31'd0, in_ready}, 32'd0);
        chk("rst.no_hs", hs_cnt, 32'd0);
        in_valid = 1'b0;
        resetn   = 1'b1;
        #1;
        chk("rst.rdy_rel", {31'd0, in_ready}, 32'd1);

        // 0x55, one cycle per bit, no parity
        in_data = 8'h55; in_valid = 1'b1; divisor = 16'd0;
        frame("f55", 8'h55, 0, 1'b0, 1'b0, 8'h00, 1'b0, -1, 16'd0);

        // 0xA7, four cycles per bit, even then odd parity
        in_data = 8'hA7; in_valid = 1'b1; divisor = 16'd3; parity_en = 1'b1; parity_odd = 1'b0;
        frame("a7e", 8'hA7, 3, 1'b1, 1'b0, 8'h00, 1'b0, -1, 16'd0);
        in_data = 8'hA7; in_valid = 1'b1; parity_odd = 1'b1;
        frame("a7o", 8'hA7, 3, 1'b1, 1'b1, 8'h00, 1'b0, -1, 16'd0);

        // FIFO stream: three back-to-back frames with in_valid held high
        parity_en = 1'b0; parity_odd = 1'b0; divisor = 16'd1;
        in_data = 8'h01; in_valid = 1'b1;
        h0 = hs_cnt;
        frame("q01", 8'h01, 1, 1'b0, 1'b0, 8'h02, 1'b1, -1, 16'd0);
        frame("q02", 8'h02, 1, 1'b0, 1'b0, 8'h03, 1'b1, -1, 16'd0);
        frame("q03", 8'h03, 1, 1'b0, 1'b0, 8'h00, 1'b0, -1, 16'd0);
        chk("q.handshakes", hs_cnt - h0, 32'd3);

        // divisor changed during the second data bit only affects the next frame
        in_data = 8'h5A; in_valid = 1'b1; divisor = 16'd1;
        frame("div1", 8'h5A, 1, 1'b0, 1'b0, 8'h3C, 1'b1, 4, 16'd7);
        frame("div7", 8'h3C, 7, 1'b0, 1'b0, 8'h00, 1'b0, -1, 16'd0);

        // reset during DATA discards the byte
        in_data = 8'h00; in_valid = 1'b1; divisor = 16'd1;
        h0 = hs_cnt;
        @(negedge clk);
        chk("ab.start", {31'd0, txd}, 32'd0);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("ab.busy_data", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("ab.txd", {31'd0, txd}, 32'd1);
        chk("ab.busy", {31'd0, busy}, 32'd0);
        chk("ab.rdy_rst", {31'd0, in_ready}, 32'd0);
        resetn = 1'b1;
        #1;
        chk("ab.rdy_rel", {31'd0, in_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("ab.no_resend", bad, 32'd0);
        chk("ab.handshakes", hs_cnt - h0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
